// File: rtl/vga_scanout_6bit.sv
// vga_scanout_6bit: read side of the 640x480 video memory.
// Walks a free-running VGA raster, fetches one 6-bit pixel per visible
// position through the videoMem read port, and drives registered sync,
// blank and colour outputs. It also reports frame and vertical-blank
// status so that redraws can be scheduled during vertical blank.
//
// Ports:
//   clk         system clock
//   rst         synchronous, active-high reset
//   pix_en      pixel-rate strobe; raster state advances only when it is high
//   raddr       videoMem read address (registered)
//   rdata       videoMem read data, valid one clk after raddr
//   test_en     colour-bar override (only with SCANOUT_TESTPAT_EN)
//   hsync       active-low horizontal sync
//   vsync       active-low vertical sync
//   blank_n     high during visible pixels
//   vga_r/g/b   2-bit colour channels; pixel bits [5:4]=R, [3:2]=G, [1:0]=B
//   frame_start high in the clk whose pix_en edge wraps the raster to (0,0)
//   vblank      high while the line counter is >= V_VIS
//
// Optional feature macro: SCANOUT_TESTPAT_EN (adds test_en and colour bars).
module vga_scanout_6bit #(
    parameter int unsigned H_VIS  = 640,
    parameter int unsigned H_FP   = 16,
    parameter int unsigned H_SYNC = 96,
    parameter int unsigned H_BP   = 48,
    parameter int unsigned V_VIS  = 480,
    parameter int unsigned V_FP   = 10,
    parameter int unsigned V_SYNC = 2,
    parameter int unsigned V_BP   = 33
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        pix_en,
    output logic [18:0] raddr,
    input  logic [5:0]  rdata,
`ifdef SCANOUT_TESTPAT_EN
    input  logic        test_en,
`endif
    output logic        hsync,
    output logic        vsync,
    output logic        blank_n,
    output logic [1:0]  vga_r,
    output logic [1:0]  vga_g,
    output logic [1:0]  vga_b,
    output logic        frame_start,
    output logic        vblank
);

    localparam int unsigned CW           = 10;
    localparam int unsigned AW           = 19;
    localparam int unsigned H_TOTAL      = H_VIS + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL      = V_VIS + V_FP + V_SYNC + V_BP;
    localparam int unsigned H_SYNC_START = H_VIS + H_FP;
    localparam int unsigned H_SYNC_STOP  = H_SYNC_START + H_SYNC;
    localparam int unsigned V_SYNC_START = V_VIS + V_FP;
    localparam int unsigned V_SYNC_STOP  = V_SYNC_START + V_SYNC;

    logic [CW-1:0] hcnt;
    logic [CW-1:0] vcnt;
    logic          h_end;
    logic          v_end;
    logic          visible;
    logic          last_visible;
    logic          hsync_raw;
    logic          vsync_raw;
    logic [5:0]    pix_src;

    // Raster position decode
    assign h_end        = (hcnt == CW'(H_TOTAL - 1));
    assign v_end        = (vcnt == CW'(V_TOTAL - 1));
    assign visible      = (hcnt < CW'(H_VIS)) && (vcnt < CW'(V_VIS));
    assign last_visible = (hcnt == CW'(H_VIS - 1)) && (vcnt == CW'(V_VIS - 1));
    assign hsync_raw    = !((hcnt >= CW'(H_SYNC_START)) && (hcnt < CW'(H_SYNC_STOP)));
    assign vsync_raw    = !((vcnt >= CW'(V_SYNC_START)) && (vcnt < CW'(V_SYNC_STOP)));

    // Status: decoded straight from the counters, so aligned to the raster
    // position rather than to the delayed output stage.
    assign frame_start  = pix_en && !rst && h_end && v_end;
    assign vblank       = (vcnt >= CW'(V_VIS));

`ifdef SCANOUT_TESTPAT_EN
    // Eight equal-width bars across the visible line; bar index k maps to
    // {k2,k2,k1,k1,k0,k0} so each bar is a saturated primary/secondary.
    logic [2:0] bar;
    assign bar     = 3'(hcnt / CW'(H_VIS / 8));
    assign pix_src = test_en ? {bar[2], bar[2], bar[1], bar[1], bar[0], bar[0]} : rdata;
`else
    assign pix_src = rdata;
`endif

    // Raster counters
    always_ff @(posedge clk) begin
        if (rst) begin
            hcnt <= '0;
            vcnt <= '0;
        end else if (pix_en) begin
            hcnt <= h_end ? '0 : hcnt + CW'(1);
            if (h_end) begin
                vcnt <= v_end ? '0 : vcnt + CW'(1);
            end
        end
    end

    // Read address: tracks vcnt*H_VIS+hcnt while visible, holds in blanking
    always_ff @(posedge clk) begin
        if (rst) begin
            raddr <= '0;
        end else if (pix_en && visible) begin
            raddr <= last_visible ? '0 : raddr + AW'(1);
        end
    end

    // Output stage: one pix_en behind the counters; colour gated by visibility
    always_ff @(posedge clk) begin
        if (rst) begin
            hsync   <= 1'b1;
            vsync   <= 1'b1;
            blank_n <= 1'b0;
            vga_r   <= '0;
            vga_g   <= '0;
            vga_b   <= '0;
        end else if (pix_en) begin
            hsync   <= hsync_raw;
            vsync   <= vsync_raw;
            blank_n <= visible;
            {vga_r, vga_g, vga_b} <= visible ? pix_src : 6'd0;
        end
    end

endmodule

// File: tb/tb_vga_scanout_6bit.sv
// Scoreboard bench for vga_scanout_6bit on a reduced raster (8x4 visible,
// 15x8 total) so several whole frames fit in a short run. The stimulus
// process pushes the expected post-edge outputs for every clk; the monitor
// pops and compares one entry per clk.
module tb_vga_scanout_6bit;

    localparam int unsigned HV = 8;
    localparam int unsigned HF = 2;
    localparam int unsigned HS = 3;
    localparam int unsigned HB = 2;
    localparam int unsigned VV = 4;
    localparam int unsigned VF = 1;
    localparam int unsigned VS = 2;
    localparam int unsigned VB = 1;
    localparam int unsigned HT = HV + HF + HS + HB;
    localparam int unsigned VT = VV + VF + VS + VB;
    localparam int unsigned FRAME = HT * VT;

    typedef struct {
        logic        hs;
        logic        vs;
        logic        bn;
        logic [5:0]  rgb;
        logic [18:0] ra;
        logic        vb;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        pix_en = 1'b0;
    logic [18:0] raddr;
    logic [5:0]  rdata;
    logic        hsync, vsync, blank_n, frame_start, vblank;
    logic [1:0]  vga_r, vga_g, vga_b;
    bit          force_3f = 1'b0;
    bit          tp = 1'b0;

    exp_t q[$];
    exp_t cur;
    int   fs_hits[$];
    int   checks = 0;
    int   errors = 0;
    int   h = 0;
    int   v = 0;
    int   en_cnt = 0;
    bit   running = 1'b0;

    always #5 clk = ~clk;

    // Memory model: asynchronous read returning the low address bits
    assign rdata = force_3f ? 6'h3F : raddr[5:0];

`ifdef SCANOUT_TESTPAT_EN
    logic test_en;
    assign test_en = tp;
`endif

    vga_scanout_6bit #(
        .H_VIS(HV), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_VIS(VV), .V_FP(VF), .V_SYNC(VS), .V_BP(VB)
    ) dut (
        .clk(clk),
        .rst(rst),
        .pix_en(pix_en),
        .raddr(raddr),
        .rdata(rdata),
`ifdef SCANOUT_TESTPAT_EN
        .test_en(test_en),
`endif
        .hsync(hsync),
        .vsync(vsync),
        .blank_n(blank_n),
        .vga_r(vga_r),
        .vga_g(vga_g),
        .vga_b(vga_b),
        .frame_start(frame_start),
        .vblank(vblank)
    );

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (pos %0d,%0d t=%0t)", name, act, req, h, v, $time);
        end
    endtask

    // Address expected once the raster sits at (hh,vv)
    function automatic logic [18:0] exp_raddr(input int hh, input int vv);
        if (hh < int'(HV) && vv < int'(VV)) return 19'(vv * int'(HV) + hh);
        if (vv < int'(VV) - 1) return 19'((vv + 1) * int'(HV));
        return 19'd0;
    endfunction

    function automatic logic [5:0] bar_colour(input int hh);
        logic [2:0] k;
        k = 3'(hh / int'(HV / 8));
        return {k[2], k[2], k[1], k[1], k[0], k[0]};
    endfunction

    // One clk of stimulus plus the expected outputs after its rising edge
    task automatic step(input logic en, input logic r);
        logic       fs_exp;
        logic       vis;
        logic [5:0] pixel;
        int         addr;
        @(negedge clk);
        pix_en = en;
        rst    = r;
        fs_exp = en && !r && (h == int'(HT) - 1) && (v == int'(VT) - 1);
        #1;
        chk("frame_start", int'(frame_start), int'(fs_exp));
        if (frame_start) fs_hits.push_back(en_cnt + 1);
        if (r) begin
            cur.hs = 1'b1; cur.vs = 1'b1; cur.bn = 1'b0;
            cur.rgb = 6'd0; cur.ra = 19'd0; cur.vb = 1'b0;
            h = 0; v = 0; en_cnt = 0;
        end else if (en) begin
            vis   = (h < int'(HV)) && (v < int'(VV));
            addr  = v * int'(HV) + h;
            pixel = force_3f ? 6'h3F : (tp ? bar_colour(h) : 6'(addr));
            cur.hs  = !((h >= int'(HV + HF)) && (h < int'(HV + HF + HS)));
            cur.vs  = !((v >= int'(VV + VF)) && (v < int'(VV + VF + VS)));
            cur.bn  = vis;
            cur.rgb = vis ? pixel : 6'd0;
            h = h + 1;
            if (h == int'(HT)) begin
                h = 0;
                v = (v == int'(VT) - 1) ? 0 : v + 1;
            end
            cur.ra = exp_raddr(h, v);
            cur.vb = (v >= int'(VV));
            en_cnt++;
        end
        q.push_back(cur);
        running = 1'b1;
    endtask

    // Monitor: one scoreboard entry per clk, sampled just after the edge
    always @(posedge clk) begin
        if (running) begin
            #1;
            if (q.size() == 0) begin
                chk("queue_underflow", 1, 0);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("hsync", int'(hsync), int'(e.hs));
                chk("vsync", int'(vsync), int'(e.vs));
                chk("blank_n", int'(blank_n), int'(e.bn));
                chk("rgb", int'({vga_r, vga_g, vga_b}), int'(e.rgb));
                chk("raddr", int'(raddr), int'(e.ra));
                chk("vblank", int'(vblank), int'(e.vb));
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: timeout, got no finish, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset, including with pix_en low
        step(1'b0, 1'b1);
        step(1'b1, 1'b1);
        step(1'b0, 1'b1);

        // Two frames at full rate: two frame_start pulses one frame apart
        fs_hits.delete();
        repeat (2 * FRAME) step(1'b1, 1'b0);
        chk("fs_count_full", fs_hits.size(), 2);
        if (fs_hits.size() == 2) begin
            chk("fs_first_full", fs_hits[0], 120);
            chk("fs_spacing_full", fs_hits[1] - fs_hits[0], 120);
        end

        // Memory returns 3F: colour must still be 0 during blanking
        force_3f = 1'b1;
        repeat (FRAME) step(1'b1, 1'b0);
        force_3f = 1'b0;

        // Half rate: same output stream, state frozen on idle clks
        fs_hits.delete();
        repeat (FRAME) begin
            step(1'b1, 1'b0);
            step(1'b0, 1'b0);
        end
        chk("fs_count_half", fs_hits.size(), 1);

        // Mid-frame reset at (5,2), then one full frame to the next pulse
        for (int i = 0; i < int'(2 * FRAME); i++) begin
            if (h == 5 && v == 2) break;
            step(1'b1, 1'b0);
        end
        chk("reached_mid_h", h, 5);
        chk("reached_mid_v", v, 2);
        step(1'b1, 1'b1);
        fs_hits.delete();
        repeat (FRAME + 5) step(1'b1, 1'b0);
        chk("fs_count_after_rst", fs_hits.size(), 1);
        if (fs_hits.size() == 1) chk("fs_after_rst", fs_hits[0], 120);

`ifdef SCANOUT_TESTPAT_EN
        // Colour bars: one pixel per bar on this raster
        tp = 1'b1;
        repeat (FRAME) step(1'b1, 1'b0);
        tp = 1'b0;
`endif

        @(negedge clk);
        running = 1'b0;
        chk("queue_drain", q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/vga_scanout_6bit.md
# vga_scanout_6bit

Read side of the 640×480 video memory that the image/font placer writes. It walks a VGA 640×480@60 raster, fetches one 6-bit pixel per visible position from videoMem through its read port, and drives the registered sync, blank and colour outputs to the DAC/connector. It also reports frame and blanking status, so the placer can schedule redraws during vertical blank.

## Interface
- H_VIS, 640, visible pixels per line
- H_FP, 16, horizontal front porch
- H_SYNC, 96, hsync width
- H_BP, 48, horizontal back porch
- V_VIS, 480, visible lines
- V_FP, 10, vertical front porch
- V_SYNC, 2, vsync width
- V_BP, 33, vertical back porch

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- pix_en  in  1  pixel-rate strobe; all raster state advances only on clk edges with pix_en=1
- raddr  out  19  videoMem read address, registered
- rdata  in  6  videoMem read data, valid one clk after raddr
- hsync  out  1  active-low horizontal sync
- vsync  out  1  active-low vertical sync
- blank_n  out  1  high during visible pixels
- vga_r, vga_g, vga_b  out  2 each  colour; pixel bits [5:4]=R, [3:2]=G, [1:0]=B
- frame_start  out  1  one-clk pulse on the pix_en edge where the raster returns to (0,0)
- vblank  out  1  high while the line counter is ≥ V_VIS (counter-aligned, not output-aligned)

## Operation
- Counters:
  - hcnt runs 0..799 and wraps to 0.
  - On the hcnt wrap, vcnt advances through 0..524 and wraps to 0.
  - Both counters change only on pix_en.
- A position is visible when hcnt<H_VIS and vcnt<V_VIS.
- Address counter raddr:
  - Increments on each pix_en taken while the current position is visible.
  - Wraps to 0 on the pix_en at (639,479).
  - Invariant: while (hcnt,vcnt) is visible, raddr == vcnt*640+hcnt. Max value is 307199; 19 bits, no overflow.
  - Holds during blanking.
- Raw sync, decoded from the counters:
  - hsync_raw low for hcnt in [656,751].
  - vsync_raw low for vcnt in [490,491].
- Output stage, registered and updated on pix_en:
  - hsync, vsync and blank_n take the raw values of the previous raster position.
  - RGB takes rdata when that previous position was visible; otherwise 0.
- Output RGB is forced to 0 whenever blank_n=0. The pixel value 6'h24 is displayed as-is; transparency applies only on the write side.
- frame_start is asserted for exactly the clk in which the counters move from (799,524) to (0,0). It is never asserted on a clk with pix_en=0.
- There is no state machine beyond the two counters. The raster is free-running.

## Timing
- Reset values:
  - hcnt=0, vcnt=0, raddr=0.
  - hsync=1, vsync=1, blank_n=0, vga_r/g/b=0.
  - frame_start=0, vblank=0.
- Reset asserted mid-frame aborts the frame. The first pix_en after rst is released processes position (0,0) and reads raddr=0. No partial sync pulse is extended.
- Read latency: raddr is stable for a whole pixel period. rdata is sampled at the next pix_en, so pix_en may be asserted every clk, and any pix_en spacing of 1 or more is legal.
- Output latency: outputs lag the counters by exactly one pix_en. The pixel at (h,v) appears on vga_* in the pixel period after the counters leave (h,v).
- pix_en held low freezes all state and outputs.

## Configuration
- SCANOUT_TESTPAT_EN:
  - Defined: adds input test_en (1 bit). When test_en=1, the output stage replaces rdata with a colour-bar pattern of 8 bars, each 80 pixels wide. Bar index k=hcnt[9:0]/80; colour = {k[2],k[2],k[1],k[1],k[0],k[0]}. raddr sequencing is unchanged.
  - Undefined: test_en port does not exist and rdata is always displayed.

## Test plan
- Reset, then pix_en every clk for 2 frames (840000 pixel edges) → hsync low for 96 pixels per line starting at output pixel 656; vsync low for 2 lines starting at line 490; frame_start pulses exactly twice, 420000 pix_en apart.
- Memory model returns rdata=raddr[5:0] → for every visible output pixel, RGB == (v*640+h)[5:0]; blank_n=0 with RGB=0 for h≥640 or v≥480.
- rdata forced to 6'h3F during blanking → vga_r/g/b remain 0 while blank_n=0.
- pix_en on every 2nd clk → identical output sequence to scenario 1 at half rate; raddr reaches 307199 at (639,479) and is 0 at the next visible pixel.
- Assert rst for 1 clk at (300,200) → on the next clk hsync=1, vsync=1, blank_n=0, raddr=0; the next frame_start occurs 420000 pix_en later.
- With SCANOUT_TESTPAT_EN defined and test_en=1 → line 0 shows 6'h00 for h 0–79, 6'h03 for h 80–159, … 6'h3F for h 560–639.
